ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_if.sv | 27 ++
 rtl/ex_mem_stage.sv | 63 ++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX/MEM stage signal bundle (EX-side inputs, registered MEM-side outputs, hazard selects).
interface ex_mem_if;
  logic        stall_i, flush_i, ex_valid_i, alu_zero_i;
  logic [31:0] alu_result_i, rt_data_i, branch_target_i;
  logic [4:0]  write_reg_i, id_ex_rs_i, id_ex_rt_i, mem_wb_write_reg_i;
  logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i, branch_ne_i;
  logic        mem_wb_reg_write_i;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, pc_src_o;
  logic [31:0] alu_result_o, write_data_o, branch_target_o;
  logic [4:0]  write_reg_o;
  logic [1:0]  forward_a_o, forward_b_o;
  logic [15:0] taken_cnt_o;
  modport master (
    output stall_i, flush_i, ex_valid_i, alu_zero_i, alu_result_i, rt_data_i, branch_target_i,
           write_reg_i, id_ex_rs_i, id_ex_rt_i, mem_wb_write_reg_i, reg_write_i, mem_read_i,
           mem_write_i, mem_to_reg_i, branch_i, branch_ne_i, mem_wb_reg_write_i,
    input  valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, pc_src_o, alu_result_o,
           write_data_o, branch_target_o, write_reg_o, forward_a_o, forward_b_o, taken_cnt_o
  );
  modport slave (
    input  stall_i, flush_i, ex_valid_i, alu_zero_i, alu_result_i, rt_data_i, branch_target_i,
           write_reg_i, id_ex_rs_i, id_ex_rt_i, mem_wb_write_reg_i, reg_write_i, mem_read_i,
           mem_write_i, mem_to_reg_i, branch_i, branch_ne_i, mem_wb_reg_write_i,
    output valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, pc_src_o, alu_result_o,
           write_data_o, branch_target_o, write_reg_o, forward_a_o, forward_b_o, taken_cnt_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolve, taken counter and forwarding (EX_MEM_FWD_EN).
module ex_mem_stage (
  input logic   clk_i,
  input logic   rst_i,
  ex_mem_if.slave bus
);
  logic        valid_q, rw_q, mr_q, mw_q, m2r_q, br_q, bne_q, zero_q, pc_src;
  logic [31:0] alu_q, wd_q, bt_q;
  logic [4:0]  wr_q;
  logic [15:0] cnt_q;
  assign pc_src = valid_q & br_q & (zero_q ^ bne_q);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      {valid_q, rw_q, mr_q, mw_q, m2r_q, br_q, bne_q, zero_q} <= '0;
      alu_q <= '0;
      wd_q  <= '0;
      bt_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (bus.flush_i) begin
      {valid_q, rw_q, mr_q, mw_q, m2r_q, br_q, bne_q, zero_q} <= '0;
    end else if (!bus.stall_i) begin
      valid_q <= bus.ex_valid_i;
      rw_q    <= bus.reg_write_i & bus.ex_valid_i;
      mr_q    <= bus.mem_read_i & bus.ex_valid_i;
      mw_q    <= bus.mem_write_i & bus.ex_valid_i;
      m2r_q   <= bus.mem_to_reg_i & bus.ex_valid_i;
      br_q    <= bus.branch_i & bus.ex_valid_i;
      bne_q   <= bus.branch_ne_i & bus.ex_valid_i;
      zero_q  <= bus.alu_zero_i & bus.ex_valid_i;
      alu_q   <= bus.alu_result_i;
      wd_q    <= bus.rt_data_i;
      bt_q    <= bus.branch_target_i;
      wr_q    <= bus.write_reg_i;
      cnt_q   <= (pc_src && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end
  assign bus.valid_o         = valid_q;
  assign bus.reg_write_o     = rw_q;
  assign bus.mem_read_o      = mr_q;
  assign bus.mem_write_o     = mw_q;
  assign bus.mem_to_reg_o    = m2r_q;
  assign bus.alu_result_o    = alu_q;
  assign bus.write_data_o    = wd_q;
  assign bus.branch_target_o = bt_q;
  assign bus.write_reg_o     = wr_q;
  assign bus.pc_src_o        = pc_src;
  assign bus.taken_cnt_o     = cnt_q;
`ifdef EX_MEM_FWD_EN
  logic ex_ok, wb_ok;
  assign ex_ok = valid_q & rw_q & (wr_q != 5'd0);
  assign wb_ok = bus.mem_wb_reg_write_i & (bus.mem_wb_write_reg_i != 5'd0);
  // EX/MEM result is newer than MEM/WB, so it wins on a double match
  assign bus.forward_a_o = (ex_ok && wr_q == bus.id_ex_rs_i) ? 2'b10 :
                           (wb_ok && bus.mem_wb_write_reg_i == bus.id_ex_rs_i) ? 2'b01 : 2'b00;
  assign bus.forward_b_o = (ex_ok && wr_q == bus.id_ex_rt_i) ? 2'b10 :
                           (wb_ok && bus.mem_wb_write_reg_i == bus.id_ex_rt_i) ? 2'b01 : 2'b00;
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.id_ex_rs_i, bus.id_ex_rt_i, bus.mem_wb_write_reg_i, bus.mem_wb_reg_write_i};
  assign bus.forward_a_o = 2'b00;
  assign bus.forward_b_o = 2'b00;
`endif
endmodule
